replica_exchange_node: RTL and testbench

- Per-replica endpoint of the replica-exchange route stream; the receiving/responding end of the exchange command issued by the exchange scheduler.
- On an exchange command it streams its own route (replica_data_t beats, 8 cities × 7 bit) and total distance to both neighbours.
- In the same window it captures the route and distance of the selected neighbour (PREV/FOLW) or itself (SELF) into a shadow bank, then commits by bank swap.
- The annealing engine reads the live route through a registered read port.

---
 rtl/replica_exchange_node.sv | 180 ++++++++++++++++++
 tb/tb_replica_exchange_node.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/replica_exchange_node.sv
// rtl/replica_exchange_node.sv - replica-exchange route endpoint with shadow-bank capture and swap
//
// Purpose: holds one replica's route (CITY_DIV beats of 8 x 7-bit cities) and
// total distance. On an exchange command it streams its own route to both
// neighbours while capturing the selected source (own stream, prev or folw)
// into a shadow bank, then makes the shadow live with a single bank swap.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   command_valid, command     exchange command strobe (NOP/SELF/PREV/FOLW)
//   busy, done                 exchange in progress / one-cycle commit pulse
//   out_valid/data/distance    transmit stream to both neighbours
//   prev_*, folw_*             receive streams from lower-/higher-beta neighbours
//   init_valid/addr/data       direct beat write to the live bank (idle only)
//   init_distance_valid/..     direct distance load (idle only)
//   rd_addr, rd_data           registered read port on the live bank
//   distance                   live distance
module replica_exchange_node #(
  parameter int CITY_NUM     = 30,
  parameter int CITY_DIV     = (CITY_NUM + 7) / 8,
  parameter int CITY_DIV_LOG = $clog2(CITY_DIV)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    command_valid,
  input  logic [1:0]              command,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  output logic [55:0]             out_data,
  output logic [17:0]             out_distance,
  input  logic                    prev_valid,
  input  logic [55:0]             prev_data,
  input  logic [17:0]             prev_distance,
  input  logic                    folw_valid,
  input  logic [55:0]             folw_data,
  input  logic [17:0]             folw_distance,
  input  logic                    init_valid,
  input  logic [CITY_DIV_LOG-1:0] init_addr,
  input  logic [55:0]             init_data,
  input  logic                    init_distance_valid,
  input  logic [17:0]             init_distance,
  input  logic [CITY_DIV_LOG-1:0] rd_addr,
  output logic [55:0]             rd_data,
  output logic [17:0]             distance
);

  localparam int CNT_W = CITY_DIV_LOG + 1;
  localparam logic [CNT_W-1:0] DIV_C = CNT_W'(CITY_DIV);

  typedef enum logic [1:0] {CMD_NOP, CMD_SELF, CMD_PREV, CMD_FOLW} exchange_command_t;
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_COMMIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  exchange_command_t src_q, src_d;
  logic              live_sel_q, live_sel_d;

  // Route storage is deliberately left without reset.
  logic [55:0] bank_q [2][CITY_DIV];
  logic [17:0] dist_q [2];
  logic [55:0] rd_data_q;

  logic        init_we, init_dist_we, rx_we, rx_dist_we;
  logic        src_valid;
  logic [55:0] src_data;
  logic [17:0] src_distance;

  // Transmit side: combinational from the live bank so beat k appears in the
  // cycle right after edge k, letting lockstep neighbours capture it on edge k+1.
  always_comb begin
    out_valid    = (state_q == ST_XFER) && (tx_cnt_q < DIV_C);
    out_data     = '0;
    out_distance = '0;
    if (out_valid) begin
      out_data     = bank_q[live_sel_q][tx_cnt_q[CITY_DIV_LOG-1:0]];
      out_distance = dist_q[live_sel_q];
    end
  end

  // SELF loops our own transmit stream back into the shadow bank.
  always_comb begin
    src_valid    = 1'b0;
    src_data     = '0;
    src_distance = '0;
    case (src_q)
      CMD_SELF: begin src_valid = out_valid;  src_data = out_data;  src_distance = out_distance;  end
      CMD_PREV: begin src_valid = prev_valid; src_data = prev_data; src_distance = prev_distance; end
      CMD_FOLW: begin src_valid = folw_valid; src_data = folw_data; src_distance = folw_distance; end
      default:  ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tx_cnt_d     = tx_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    src_d        = src_q;
    live_sel_d   = live_sel_q;
    busy         = 1'b0;
    done         = 1'b0;
    init_we      = 1'b0;
    init_dist_we = 1'b0;
    rx_we        = 1'b0;
    rx_dist_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        init_we      = init_valid;
        init_dist_we = init_distance_valid;
        if (command_valid && (command != CMD_NOP)) begin
          state_d  = ST_XFER;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          src_d    = exchange_command_t'(command);
        end
      end
      ST_XFER: begin
        busy = 1'b1;
        if (tx_cnt_q < DIV_C) tx_cnt_d = tx_cnt_q + 1'b1;
        if (src_valid && (rx_cnt_q < DIV_C)) begin
          rx_we      = 1'b1;
          rx_dist_we = (rx_cnt_q == '0);
          rx_cnt_d   = rx_cnt_q + 1'b1;
        end
        // Looks at the updated count so the last rx beat moves straight to COMMIT.
        if (rx_cnt_d == DIV_C) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        busy       = 1'b1;
        done       = 1'b1;
        live_sel_d = ~live_sel_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      src_q      <= CMD_NOP;
      live_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      src_q      <= src_d;
      live_sel_q <= live_sel_d;
    end
  end

  // init writes target the live bank, rx writes the shadow; they never coincide.
  always_ff @(posedge clk) begin
    if (init_we) bank_q[live_sel_q][init_addr] <= init_data;
    if (rx_we)   bank_q[~live_sel_q][rx_cnt_q[CITY_DIV_LOG-1:0]] <= src_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dist_q[0] <= '0;
      dist_q[1] <= '0;
    end else begin
      if (init_dist_we) dist_q[live_sel_q]  <= init_distance;
      if (rx_dist_we)   dist_q[~live_sel_q] <= src_distance;
    end
  end

  // Read through the next-cycle bank select so the swap edge already returns the new route.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= bank_q[live_sel_d][rd_addr];
  end

  assign rd_data  = rd_data_q;
  assign distance = dist_q[live_sel_q];

endmodule

// File: tb/tb_replica_exchange_node.sv
// tb/tb_replica_exchange_node.sv - self-checking bench for replica_exchange_node
module tb_replica_exchange_node;

  localparam logic [1:0] NOP = 2'd0, SELF = 2'd1, PREV = 2'd2, FOLW = 2'd3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // node 0 drives
  logic c0_v, i0_v, id0_v;
  logic [1:0] c0_cmd, i0_a, rd0_a;
  logic [55:0] i0_d;
  logic [17:0] id0;
  // node 1 drives
  logic c1_v, i1_v, id1_v;
  logic [1:0] c1_cmd, i1_a, rd1_a;
  logic [55:0] i1_d;
  logic [17:0] id1;
  // prev stream into node 0
  logic pv;
  logic [55:0] pd;
  logic [17:0] pdist;
  logic link;

  logic busy0, done0, ov0, busy1, done1, ov1;
  logic [55:0] od0, rdd0, od1, rdd1;
  logic [17:0] odist0, dist0, odist1, dist1;

  logic f0_v;
  logic [55:0] f0_d;
  logic [17:0] f0_dist;
  assign f0_v    = link ? ov1 : 1'b0;
  assign f0_d    = link ? od1 : 56'd0;
  assign f0_dist = link ? odist1 : 18'd0;

  replica_exchange_node n0 (
    .clk(clk), .reset(reset), .command_valid(c0_v), .command(c0_cmd),
    .busy(busy0), .done(done0), .out_valid(ov0), .out_data(od0), .out_distance(odist0),
    .prev_valid(pv), .prev_data(pd), .prev_distance(pdist),
    .folw_valid(f0_v), .folw_data(f0_d), .folw_distance(f0_dist),
    .init_valid(i0_v), .init_addr(i0_a), .init_data(i0_d),
    .init_distance_valid(id0_v), .init_distance(id0),
    .rd_addr(rd0_a), .rd_data(rdd0), .distance(dist0)
  );

  replica_exchange_node n1 (
    .clk(clk), .reset(reset), .command_valid(c1_v), .command(c1_cmd),
    .busy(busy1), .done(done1), .out_valid(ov1), .out_data(od1), .out_distance(odist1),
    .prev_valid(ov0), .prev_data(od0), .prev_distance(odist0),
    .folw_valid(1'b0), .folw_data(56'd0), .folw_distance(18'd0),
    .init_valid(i1_v), .init_addr(i1_a), .init_data(i1_d),
    .init_distance_valid(id1_v), .init_distance(id1),
    .rd_addr(rd1_a), .rd_data(rdd1), .distance(dist1)
  );

  // Reference: each node's live route and distance as seen by the annealing engine.
  logic [55:0] m_route [2][4];
  logic [17:0] m_dist [2];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [55:0] seq_beat(input int b);
    logic [55:0] w;
    w = '0;
    for (int j = 0; j < 8; j++)
      if (8 * b + j < 30) w[7*j +: 7] = 7'(8 * b + j);
    return w;
  endfunction

  function automatic logic [55:0] rand_beat();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[55:0];
  endfunction

  task automatic do_init(input int node);
    for (int b = 0; b < 4; b++) begin
      if (node == 0) begin
        i0_v = 1'b1; i0_a = 2'(b); i0_d = m_route[0][b]; id0_v = (b == 0); id0 = m_dist[0];
      end else begin
        i1_v = 1'b1; i1_a = 2'(b); i1_d = m_route[1][b]; id1_v = (b == 0); id1 = m_dist[1];
      end
      @(negedge clk);
    end
    i0_v = 1'b0; id0_v = 1'b0; i1_v = 1'b0; id1_v = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    c0_v = 0; c0_cmd = NOP; i0_v = 0; i0_a = 0; i0_d = 0; id0_v = 0; id0 = 0; rd0_a = 0;
    c1_v = 0; c1_cmd = NOP; i1_v = 0; i1_a = 0; i1_d = 0; id1_v = 0; id1 = 0; rd1_a = 0;
    pv = 0; pd = 0; pdist = 0; link = 0;
    repeat (3) @(negedge clk);
    n_tests++; if ({busy0, done0, ov0, busy1, done1, ov1} !== 6'b0) begin n_fail++;
      $display("FAIL reset_flags got %b exp 000000", {busy0, done0, ov0, busy1, done1, ov1}); end
    n_tests++; if ({od0, odist0, rdd0, dist0} !== '0) begin n_fail++;
      $display("FAIL reset_n0_data got %h/%h/%h/%h exp 0", od0, odist0, rdd0, dist0); end
    n_tests++; if ({od1, odist1, rdd1, dist1} !== '0) begin n_fail++;
      $display("FAIL reset_n1_data got %h/%h/%h/%h exp 0", od1, odist1, rdd1, dist1); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_self();
    for (int b = 0; b < 4; b++) m_route[0][b] = seq_beat(b);
    m_dist[0] = 18'd1234;
    do_init(0);
    c0_v = 1'b1; c0_cmd = SELF;
    @(negedge clk);
    c0_v = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      n_tests++; if (ov0 !== (c <= 4)) begin n_fail++;
        $display("FAIL self_out_valid c=%0d got %b exp %b", c, ov0, c <= 4); end
      n_tests++; if (done0 !== (c == 5) || busy0 !== (c <= 5)) begin n_fail++;
        $display("FAIL self_done_busy c=%0d got %b%b exp %b%b", c, done0, busy0, c == 5, c <= 5); end
      if (c <= 4) begin
        n_tests++; if (od0 !== m_route[0][c-1] || odist0 !== 18'd1234) begin n_fail++;
          $display("FAIL self_beat c=%0d got %h/%0d exp %h/1234", c, od0, odist0, m_route[0][c-1]); end
      end
      @(negedge clk);
    end
    for (int a = 0; a < 4; a++) begin
      rd0_a = 2'(a);
      @(negedge clk);
      n_tests++; if (rdd0 !== m_route[0][a] || dist0 !== m_dist[0]) begin n_fail++;
        $display("FAIL self_read a=%0d got %h/%0d exp %h/%0d", a, rdd0, dist0, m_route[0][a], m_dist[0]); end
    end
  endtask

  task automatic test_cross();
    int d0c, d1c;
    logic [55:0] tmp;
    for (int b = 0; b < 4; b++) begin m_route[0][b] = rand_beat(); m_route[1][b] = rand_beat(); end
    m_dist[0] = 18'd100; m_dist[1] = 18'd200;
    do_init(0); do_init(1);
    link = 1'b1;
    c0_v = 1'b1; c0_cmd = FOLW; c1_v = 1'b1; c1_cmd = PREV;
    @(negedge clk);
    c0_v = 1'b0; c1_v = 1'b0;
    d0c = 0; d1c = 0;
    for (int c = 1; c <= 10; c++) begin
      if (done0 && d0c == 0) d0c = c;
      if (done1 && d1c == 0) d1c = c;
      if (c <= 4) begin
        n_tests++; if (od0 !== m_route[0][c-1] || od1 !== m_route[1][c-1]) begin n_fail++;
          $display("FAIL cross_tx c=%0d got %h/%h exp %h/%h", c, od0, od1, m_route[0][c-1], m_route[1][c-1]); end
      end
      @(negedge clk);
    end
    n_tests++; if (d0c != 5 || d1c != 5) begin n_fail++;
      $display("FAIL cross_done_cycle got %0d/%0d exp 5/5", d0c, d1c); end
    for (int b = 0; b < 4; b++) begin tmp = m_route[0][b]; m_route[0][b] = m_route[1][b]; m_route[1][b] = tmp; end
    m_dist[0] = 18'd200; m_dist[1] = 18'd100;
    for (int a = 0; a < 4; a++) begin
      rd0_a = 2'(a); rd1_a = 2'(a);
      @(negedge clk);
      n_tests++; if (rdd0 !== m_route[0][a] || dist0 !== m_dist[0]) begin n_fail++;
        $display("FAIL cross_read_n0 a=%0d got %h/%0d exp %h/%0d", a, rdd0, dist0, m_route[0][a], m_dist[0]); end
      n_tests++; if (rdd1 !== m_route[1][a] || dist1 !== m_dist[1]) begin n_fail++;
        $display("FAIL cross_read_n1 a=%0d got %h/%0d exp %h/%0d", a, rdd1, dist1, m_route[1][a], m_dist[1]); end
    end
    link = 1'b0;
  endtask

  task automatic test_gapped();
    logic [55:0] p [4];
    logic [17:0] pdv;
    int bi, ndone;
    for (int b = 0; b < 4; b++) p[b] = rand_beat();
    pdv = 18'($urandom_range(1, 200000));
    bi = 0; ndone = 0;
    // c0: stray valid while idle, c1: beat0, c2-3 gap, c4-6: beats 1-3, c7: stray in COMMIT
    for (int c = 0; c <= 10; c++) begin
      if (c >= 1) begin
        if (done0) ndone++;
        n_tests++; if (ov0 !== (c <= 4)) begin n_fail++;
          $display("FAIL gap_out_valid c=%0d got %b exp %b", c, ov0, c <= 4); end
        n_tests++; if (done0 !== (c == 7) || busy0 !== (c <= 7)) begin n_fail++;
          $display("FAIL gap_done_busy c=%0d got %b%b exp %b%b", c, done0, busy0, c == 7, c <= 7); end
      end
      c0_v = (c == 0); c0_cmd = PREV;
      pv = 1'b0; pd = rand_beat(); pdist = pdv ^ 18'h3ffff;
      if (c == 0 || c == 7) pv = 1'b1;
      if (c == 1 || (c >= 4 && c <= 6)) begin
        pv = 1'b1; pd = p[bi]; pdist = (bi == 0) ? pdv : pdv + 18'd1; bi++;
      end
      @(negedge clk);
    end
    pv = 1'b0; c0_v = 1'b0;
    n_tests++; if (ndone != 1) begin n_fail++;
      $display("FAIL gap_done_count got %0d exp 1", ndone); end
    for (int b = 0; b < 4; b++) m_route[0][b] = p[b];
    m_dist[0] = pdv;
    for (int a = 0; a < 4; a++) begin
      rd0_a = 2'(a);
      @(negedge clk);
      n_tests++; if (rdd0 !== m_route[0][a] || dist0 !== m_dist[0]) begin n_fail++;
        $display("FAIL gap_read a=%0d got %h/%0d exp %h/%0d", a, rdd0, dist0, m_route[0][a], m_dist[0]); end
    end
  endtask

  task automatic test_ignored();
    for (int c = 0; c <= 8; c++) begin
      if (c >= 1) begin
        n_tests++; if (busy0 !== (c >= 2 && c <= 6) || done0 !== (c == 6)) begin n_fail++;
          $display("FAIL ign_busy_done c=%0d got %b%b exp %b%b", c, busy0, done0, c >= 2 && c <= 6, c == 6); end
        if (c >= 2 && c <= 5) begin
          n_tests++; if (ov0 !== 1'b1 || od0 !== m_route[0][c-2]) begin n_fail++;
            $display("FAIL ign_beat c=%0d got %b/%h exp 1/%h", c, ov0, od0, m_route[0][c-2]); end
        end
      end
      c0_v = (c <= 1 || c == 3); c0_cmd = (c == 0) ? NOP : (c == 1) ? SELF : PREV;
      i0_v = (c == 3); i0_a = 2'd1; i0_d = rand_beat();
      id0_v = (c == 3); id0 = 18'h2aaaa;
      pv = (c >= 2 && c <= 5); pd = rand_beat(); pdist = 18'd7;
      @(negedge clk);
    end
    c0_v = 0; i0_v = 0; id0_v = 0; pv = 0;
    for (int a = 0; a < 4; a++) begin
      rd0_a = 2'(a);
      @(negedge clk);
      n_tests++; if (rdd0 !== m_route[0][a] || dist0 !== m_dist[0]) begin n_fail++;
        $display("FAIL ign_read a=%0d got %h/%0d exp %h/%0d", a, rdd0, dist0, m_route[0][a], m_dist[0]); end
    end
  endtask

  task automatic test_rd_poll();
    logic [55:0] old_b, new_b;
    logic [17:0] old_d, new_d;
    old_b = m_route[0][2]; new_b = m_route[1][2];
    old_d = m_dist[0];     new_d = m_dist[1];
    link = 1'b1; rd0_a = 2'd2;
    @(negedge clk);
    for (int c = 0; c <= 8; c++) begin
      n_tests++; if (rdd0 !== ((c <= 5) ? old_b : new_b)) begin n_fail++;
        $display("FAIL poll_rd c=%0d got %h exp %h", c, rdd0, (c <= 5) ? old_b : new_b); end
      n_tests++; if (dist0 !== ((c <= 5) ? old_d : new_d)) begin n_fail++;
        $display("FAIL poll_dist c=%0d got %0d exp %0d", c, dist0, (c <= 5) ? old_d : new_d); end
      c0_v = (c == 0); c0_cmd = FOLW; c1_v = (c == 0); c1_cmd = SELF;
      @(negedge clk);
    end
    c0_v = 0; c1_v = 0; link = 1'b0;
    for (int b = 0; b < 4; b++) m_route[0][b] = m_route[1][b];
    m_dist[0] = m_dist[1];
  endtask

  task automatic test_reset_mid();
    c0_v = 1'b1; c0_cmd = SELF;
    @(negedge clk);
    c0_v = 1'b0;
    n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL rmid_beat1 got %b exp 1", ov0); end
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_tests++; if ({ov0, busy0, done0} !== 3'b0 || od0 !== '0 || odist0 !== '0) begin n_fail++;
      $display("FAIL rmid_outputs got %b%b%b/%h/%0d exp 000/0/0", ov0, busy0, done0, od0, odist0); end
    n_tests++; if (rdd0 !== '0 || dist0 !== '0 || dist1 !== '0) begin n_fail++;
      $display("FAIL rmid_state got %h/%0d/%0d exp 0/0/0", rdd0, dist0, dist1); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 4; b++) m_route[0][b] = rand_beat();
    m_dist[0] = 18'($urandom_range(0, 262143));
    do_init(0);
    c0_v = 1'b1; c0_cmd = SELF;
    @(negedge clk);
    c0_v = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      n_tests++; if (ov0 !== (c <= 4) || done0 !== (c == 5)) begin n_fail++;
        $display("FAIL rmid_self c=%0d got %b%b exp %b%b", c, ov0, done0, c <= 4, c == 5); end
      if (c <= 4) begin
        n_tests++; if (od0 !== m_route[0][c-1] || odist0 !== m_dist[0]) begin n_fail++;
          $display("FAIL rmid_beat c=%0d got %h/%0d exp %h/%0d", c, od0, odist0, m_route[0][c-1], m_dist[0]); end
      end
      @(negedge clk);
    end
    for (int a = 0; a < 4; a++) begin
      rd0_a = 2'(a);
      @(negedge clk);
      n_tests++; if (rdd0 !== m_route[0][a] || dist0 !== m_dist[0]) begin n_fail++;
        $display("FAIL rmid_read a=%0d got %h/%0d exp %h/%0d", a, rdd0, dist0, m_route[0][a], m_dist[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_self();
    test_cross();
    test_gapped();
    test_ignored();
    test_rd_poll();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
